xor_descrambler: RTL and testbench
==================================

Name: xor_descrambler

Overview:
- Serial self-synchronising descrambler. It is the receive-side counterpart of the team's XOR-based scrambler for polynomial x^7 + x^6 + 1 (1 + x^-6 + x^-7).
- Descrambles one bit per enabled clock and asserts a lock flag once its history register holds only received bits.
- Sits directly behind the serial line sampler. It is built from the library's XOR and async-reset flop primitives.

Parameters:
- WIDTH, 7, history register length; equals the highest polynomial tap.
- TAP_A, 6, lower feedback tap (1-based); legal range is 1 <= TAP_A < WIDTH.
- TAP_B, 7, upper feedback tap (1-based); must equal WIDTH. Illegal settings are a $error at elaboration.

Ports:
- CLK  input  1  clock; rising edge active.
- RN  input  1  asynchronous reset, active-low.
- D  input  1  scrambled serial data bit.
- EN  input  1  D is valid this cycle; the bit is consumed on the CLK rising edge.
- CLR  input  1  synchronous flush of history, lock and output.
- BYP  input  1  bypass: Q takes D unmodified; history still updates.
- Q  output  1  descrambled bit, registered.
- QV  output  1  Q valid strobe, registered.
- LOCK  output  1  history fully loaded with received bits.
- VDD, VSS  inout  1  supply pins; present only under USE_POWER_PINS.

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (RN).
- Reset, while RN=0, immediately and independent of CLK:
  - S (history, WIDTH bits) = 0.
  - CNT (lock counter, ceil(log2(WIDTH+1)) bits) = 0.
  - Q = 0, QV = 0, LOCK = 0.
- Release of RN takes effect at the first CLK edge with RN=1.
- Priority on each CLK rising edge with RN=1: CLR > EN > idle.
- CLR=1:
  - S = 0, CNT = 0, Q = 0, QV = 0, LOCK = 0.
  - D and EN are ignored that cycle.
- EN=1, CLR=0:
  - Q <= BYP ? D : (D ^ S[TAP_A-1] ^ S[TAP_B-1]).
  - S <= {S[WIDTH-2:0], D}. Shifting always uses the raw received D, never Q, so the block is self-synchronising.
  - QV <= 1.
  - CNT <= (CNT == WIDTH) ? WIDTH : CNT + 1; CNT saturates and never wraps.
  - LOCK <= (CNT + 1 >= WIDTH).
- EN=0, CLR=0:
  - S, CNT, LOCK and Q hold.
  - QV <= 0. QV is a single-cycle strobe per accepted bit.
- Latency: exactly 1 cycle from accepted D to Q/QV.
- Full throughput: EN may be high on every cycle.
- Before LOCK, Q is the arithmetic result against the zero-filled history. It is valid-strobed but not guaranteed correct; downstream logic gates on LOCK.
- Transfer function: once locked, Q(n) = D(n) ^ D(n-TAP_A) ^ D(n-TAP_B), counting accepted bits only. Idle cycles do not advance n.
- BYP toggling mid-stream does not disturb S, CNT or LOCK.
- CLR or reset mid-stream: the next accepted bit is treated as bit 1. LOCK re-asserts after WIDTH further accepted bits.
- Lock state machine (derived from CNT):
  - States: UNLOCKED (CNT < WIDTH) and LOCKED (CNT == WIDTH).
  - Transitions: only CLR or RN leave LOCKED; there is no error-driven unlock.
- No combinational path from any input to any output.

Test Plan:
- RN pulsed low mid-cycle with prior S nonzero -> Q=QV=LOCK=0 immediately, without a CLK edge. After release, the first accepted D=1 gives Q=1.
- From reset, EN=1 with D=1 for 8 cycles -> Q sequence 1,1,1,1,1,1,0,1. QV high each cycle after the first edge. LOCK rises on the same edge as the 7th Q.
- Scrambler model seeded 0x5A, scrambling a 256-bit PRBS9 stream, into the DUT with random EN gaps -> after LOCK, Q matches the source bit-exactly. QV count equals the EN=1 count; no QV on gap cycles.
- Locked stream, CLR asserted together with EN=1 -> that bit is dropped, QV=0 and LOCK=0 next cycle. LOCK returns after 7 more accepted bits.
- BYP=1 for 10 bits mid-stream, then BYP=0 -> during bypass Q==D delayed 1 cycle. The first bit after bypass descrambles correctly with no relock and LOCK stays 1.
- CNT saturation: 1000 accepted bits -> LOCK stays 1 and CNT never exceeds 7. Checked by assertion.

Source files
------------

// File: rtl/xor_descrambler.sv
// Self-synchronising serial descrambler for 1 + x^-6 + x^-7: one bit per EN, Q/QV registered (1-cycle latency).
// Full throughput, no backpressure; LOCK flags when the history holds WIDTH received bits.
module xor_descrambler #(
  parameter int WIDTH = 7,
  parameter int TAP_A = 6,
  parameter int TAP_B = 7
) (
`ifdef USE_POWER_PINS
  inout  wire  VDD,
  inout  wire  VSS,
`endif
  input  logic CLK,
  input  logic RN,
  input  logic D,
  input  logic EN,
  input  logic CLR,
  input  logic BYP,
  output logic Q,
  output logic QV,
  output logic LOCK
);

  localparam int CW = $clog2(WIDTH + 1);

  generate
    if (TAP_B != WIDTH || TAP_A < 1 || TAP_A >= WIDTH) begin : g_bad_taps
      $error("xor_descrambler: illegal taps TAP_A=%0d TAP_B=%0d WIDTH=%0d", TAP_A, TAP_B, WIDTH);
    end
  endgenerate

  logic [WIDTH-1:0] hist;
  logic [CW-1:0]    cnt;
  logic [CW:0]      cnt_inc;
  logic             fb;

  assign cnt_inc = {1'b0, cnt} + (CW+1)'(1);
  assign fb      = hist[TAP_A-1] ^ hist[TAP_B-1];

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      hist <= '0;
      cnt  <= '0;
      Q    <= 1'b0;
      QV   <= 1'b0;
      LOCK <= 1'b0;
    end else if (CLR) begin
      hist <= '0;
      cnt  <= '0;
      Q    <= 1'b0;
      QV   <= 1'b0;
      LOCK <= 1'b0;
    end else if (EN) begin
      Q    <= BYP ? D : (D ^ fb);
      // history always takes the raw line bit so the receiver re-aligns by itself
      hist <= {hist[WIDTH-2:0], D};
      QV   <= 1'b1;
      cnt  <= (cnt == CW'(WIDTH)) ? cnt : cnt + CW'(1);
      LOCK <= (cnt_inc >= (CW+1)'(WIDTH));
    end else begin
      QV   <= 1'b0;
    end
  end

  cnt_saturates: assert property (@(posedge CLK) disable iff (!RN) ({1'b0, cnt} <= (CW+1)'(WIDTH)))
    else $error("xor_descrambler: lock counter exceeded WIDTH");

endmodule

// File: tb/tb_xor_descrambler.sv
// Bench for xor_descrambler: constant vector table, hand sequences, and a PRBS9 scrambler loop against a history-queue model.
module tb_xor_descrambler;

  logic CLK = 1'b0;
  logic RN, D, EN, CLR, BYP;
  logic Q, QV, LOCK;

  int nvec = 0;
  int nmis = 0;

  always #5 CLK = ~CLK;

  xor_descrambler #(.WIDTH(7), .TAP_A(6), .TAP_B(7)) dut (
    .CLK(CLK), .RN(RN), .D(D), .EN(EN), .CLR(CLR), .BYP(BYP),
    .Q(Q), .QV(QV), .LOCK(LOCK)
  );

  // reference: queue of accepted line bits since the last flush
  logic hist[$];
  logic m_q, m_qv, m_lock;

  function automatic void model_reset();
    hist.delete();
    m_q = 1'b0; m_qv = 1'b0; m_lock = 1'b0;
  endfunction

  function automatic void model_edge(logic d, logic en, logic clr, logic byp);
    logic a, b;
    if (clr) begin
      model_reset();
    end else if (en) begin
      a = (hist.size() >= 6) ? hist[hist.size()-6] : 1'b0;
      b = (hist.size() >= 7) ? hist[hist.size()-7] : 1'b0;
      m_q = byp ? d : (d ^ a ^ b);
      hist.push_back(d);
      if (hist.size() > 7) void'(hist.pop_front());
      m_qv = 1'b1;
      m_lock = (hist.size() >= 7);
    end else begin
      m_qv = 1'b0;
    end
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // apply one cycle of inputs; outputs are settled at return (#1 after the edge)
  task automatic drive(input logic d, input logic en, input logic clr, input logic byp);
    @(negedge CLK);
    D = d; EN = en; CLR = clr; BYP = byp;
    @(posedge CLK);
    model_edge(d, en, clr, byp);
    #1;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".q"}, Q, m_q);
    chk({nm, ".qv"}, QV, m_qv);
    chk({nm, ".lock"}, LOCK, m_lock);
  endtask

  typedef struct {
    logic d, en, clr, byp;
    logic q, qv, lock;
  } vec_t;

  vec_t tbl[11];

  logic [8:0] lfsr;
  logic [6:0] scr;

  task automatic next_bits(output logic src, output logic sb);
    src  = lfsr[8] ^ lfsr[4];
    lfsr = {lfsr[7:0], src};
    sb   = src ^ scr[5] ^ scr[6];
    scr  = {scr[5:0], sb};
  endtask

  initial begin
    int en_cnt, qv_cnt, k;
    logic src, sb, r;

    // all-ones from reset: Q = 1,1,1,1,1,1,0,1, LOCK on the 7th bit
    for (int i = 0; i < 8; i++)
      tbl[i] = '{d:1'b1, en:1'b1, clr:1'b0, byp:1'b0, q:(i == 6) ? 1'b0 : 1'b1, qv:1'b1, lock:(i >= 6)};
    tbl[8]  = '{d:1'b0, en:1'b0, clr:1'b0, byp:1'b0, q:1'b1, qv:1'b0, lock:1'b1};
    tbl[9]  = '{d:1'b1, en:1'b1, clr:1'b1, byp:1'b0, q:1'b0, qv:1'b0, lock:1'b0};
    tbl[10] = '{d:1'b1, en:1'b1, clr:1'b0, byp:1'b0, q:1'b1, qv:1'b1, lock:1'b0};

    RN = 1'b0; D = 1'b0; EN = 1'b0; CLR = 1'b0; BYP = 1'b0;
    model_reset();
    #12;
    chk("rst.q", Q, 1'b0);
    chk("rst.qv", QV, 1'b0);
    chk("rst.lock", LOCK, 1'b0);
    @(negedge CLK);
    RN = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].d, tbl[i].en, tbl[i].clr, tbl[i].byp);
      chk($sformatf("tbl%0d.q", i), Q, tbl[i].q);
      chk($sformatf("tbl%0d.qv", i), QV, tbl[i].qv);
      chk($sformatf("tbl%0d.lock", i), LOCK, tbl[i].lock);
    end

    // async reset mid-cycle with non-zero history
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre_arst.lock", LOCK, 1'b1);
    @(posedge CLK);
    #3 RN = 1'b0;
    #1;
    chk("arst.q", Q, 1'b0);
    chk("arst.qv", QV, 1'b0);
    chk("arst.lock", LOCK, 1'b0);
    model_reset();
    @(negedge CLK);
    RN = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("arst_first.q", Q, 1'b1);
    chk_model("arst_first");

    // scrambled PRBS9 with random EN gaps
    lfsr = 9'h1FF; scr = 7'h5A;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    en_cnt = 0; qv_cnt = 0; k = 0;
    while (k < 256) begin
      if ($urandom_range(2) == 0) begin
        drive($urandom_range(1), 1'b0, 1'b0, 1'b0);
        chk_model($sformatf("gap%0d", k));
      end else begin
        next_bits(src, sb);
        drive(sb, 1'b1, 1'b0, 1'b0);
        k++; en_cnt++;
        chk_model($sformatf("prbs%0d", k));
        if (k >= 8) chk($sformatf("prbs%0d.src", k), Q, src);
      end
      if (QV) qv_cnt++;
    end
    chk_int("qv_count", qv_cnt, en_cnt);

    // bypass mid-stream, then resume descrambling with no relock
    for (int i = 0; i < 10; i++) begin
      next_bits(src, sb);
      drive(sb, 1'b1, 1'b0, 1'b1);
      chk($sformatf("byp%0d.q", i), Q, sb);
      chk($sformatf("byp%0d.lock", i), LOCK, 1'b1);
    end
    next_bits(src, sb);
    drive(sb, 1'b1, 1'b0, 1'b0);
    chk("post_byp.src", Q, src);
    chk("post_byp.lock", LOCK, 1'b1);
    chk_model("post_byp");

    // CLR with EN on a locked stream drops the bit and restarts locking
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr.qv", QV, 1'b0);
    chk("clr.lock", LOCK, 1'b0);
    for (int i = 0; i < 7; i++) begin
      r = 1'($urandom_range(1));
      drive(r, 1'b1, 1'b0, 1'b0);
      chk($sformatf("relock%0d.lock", i), LOCK, (i == 6));
      chk_model($sformatf("relock%0d", i));
    end

    // long run: counter saturation, LOCK must never drop
    for (int i = 0; i < 1000; i++) begin
      r = 1'($urandom_range(1));
      drive(r, 1'b1, 1'b0, 1'($urandom_range(7) == 0));
      chk_model($sformatf("sat%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
